sw_debounce: RTL



---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/debounce_bit.sv | 101 ++++++++++
 rtl/sw_debounce.sv | 42 ++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
package sw_debounce_pkg;

    // Per-channel debounce state
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_t;

    // 10 ms stability window at 100 MHz
    localparam int unsigned DB_CNT_MAX_DEFAULT     = 1000000;
    localparam int unsigned DB_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: synchroniser chain, stability FSM with counter,
// registered clean level and registered one-cycle rise/fall pulses.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous raw switch level
//   clean      : debounced level
//   rise, fall : one-cycle pulses on a clean 0->1 / 1->0 transition
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int unsigned SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Plain flop chain, nothing between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state: accept a new level only after CNT_MAX consecutive differing samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync != clean_q) begin
                    state_d = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (sync == clean_q) begin
                    // Bounced back before the window expired
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    clean_d = sync;
                    rise_d  = sync;
                    fall_d  = ~sync;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: WIDTH independent synchronise+debounce channels.
//   clk, rst_n : clock, async active-low reset
//   sw_raw     : asynchronous raw switch levels
//   sw_clean   : debounced, synchronised levels
//   sw_rise    : per-bit one-cycle pulse on a clean 0->1 transition
//   sw_fall    : per-bit one-cycle pulse on a clean 1->0 transition
//   sw_changed : any rise or fall pulse this cycle
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int unsigned SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // One channel per switch bit
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    // Derived from registered pulses, so it stays aligned with them
    assign sw_changed = |(sw_rise | sw_fall);

endmodule
